// File: rtl/decap_pkg.sv
// Shared definitions for the decap scheduler: config word field positions,
// reset configuration, packet-state encoding and the port-selection rule.
package decap_pkg;

    localparam int ENABLE_BIT = 0;
    localparam int PORTS_LSB  = 8;
    localparam int PROTO_LSB  = 16;

    localparam logic [31:0] DECAP_RESET_CFG = 32'h00B20501;

    typedef enum logic {
        PKT_SOP = 1'b0,
        PKT_MID = 1'b1
    } pkt_state_e;

    function automatic logic port_sel(input logic [31:0] cfg, input logic [7:0] src_port);
        return cfg[ENABLE_BIT] & (|(src_port & cfg[PORTS_LSB +: 8]));
    endfunction

endpackage

// File: rtl/decap_cfg_scheduler_if.sv
// Config-write, monitored-stream and counter signals of the decap scheduler.
// Master drives config/stream/clear; slave (the scheduler) returns status and decisions.
interface decap_cfg_scheduler_if #(
    parameter int TUSER_W = 128
);
    logic               cfg_wr_valid;
    logic [31:0]        cfg_wr_data;
    logic               cfg_wr_ready;
    logic               cfg_pending;
    logic [31:0]        cfg_active;
    logic [7:0]         encap_proto;
    logic               axis_tvalid;
    logic               axis_tready;
    logic               axis_tlast;
    logic [TUSER_W-1:0] axis_tuser;
    logic               decap_active;
    logic               cnt_clear;
    logic [31:0]        decap_pkt_cnt;
    logic [31:0]        pass_pkt_cnt;

    modport master (
        output cfg_wr_valid, cfg_wr_data, axis_tvalid, axis_tready, axis_tlast,
               axis_tuser, cnt_clear,
        input  cfg_wr_ready, cfg_pending, cfg_active, encap_proto, decap_active,
               decap_pkt_cnt, pass_pkt_cnt
    );

    modport slave (
        input  cfg_wr_valid, cfg_wr_data, axis_tvalid, axis_tready, axis_tlast,
               axis_tuser, cnt_clear,
        output cfg_wr_ready, cfg_pending, cfg_active, encap_proto, decap_active,
               decap_pkt_cnt, pass_pkt_cnt
    );

endinterface

// File: rtl/decap_pkt_tracker.sv
// SOP/MID packet tracker; first_beat/last_beat are combinational strobes of the current beat.
// Pure observer of the stream: never applies backpressure.
module decap_pkt_tracker
    import decap_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       beat,
    input  logic       tlast,
    output pkt_state_e state,
    output logic       first_beat,
    output logic       last_beat
);

    pkt_state_e state_q, state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PKT_SOP;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        first_beat = beat & (state_q == PKT_SOP);
        last_beat  = beat & tlast;
        case (state_q)
            PKT_SOP: if (beat && !tlast) state_d = PKT_MID;
            PKT_MID: if (beat && tlast)  state_d = PKT_SOP;
            default: state_d = PKT_SOP;
        endcase
    end

    assign state = state_q;

endmodule

// File: rtl/decap_cfg_scheduler.sv
// Applies config words only at packet boundaries and holds each packet's decap decision from its first beat; counters exist when DECAP_SCHED_CNT_EN is defined.
// Decision is combinational on the first beat, config applies one edge after accept when idle; observes the stream, never stalls it.
module decap_cfg_scheduler
    import decap_pkg::*;
#(
    parameter int          C_S_AXIS_TUSER_WIDTH = 128,
    parameter int          SRC_PORT_POS         = 16,
    parameter logic [31:0] RESET_CFG            = DECAP_RESET_CFG
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    decap_cfg_scheduler_if.slave  bus
);

    logic [C_S_AXIS_TUSER_WIDTH-1:0] tuser;
    logic       beat, sel, first_beat, last_beat, accept, apply;
    pkt_state_e pkt_state;

    logic [31:0] cfg_active_q, cfg_active_d;
    logic [31:0] cfg_word_q, cfg_word_d;
    logic        cfg_pending_q, cfg_pending_d;
    logic        decision_q, decision_d;

    assign tuser = bus.axis_tuser;
    assign beat  = bus.axis_tvalid & bus.axis_tready;
    assign sel   = port_sel(cfg_active_q, tuser[SRC_PORT_POS +: 8]);

    decap_pkt_tracker u_tracker (
        .clk        (ACLK),
        .rst        (ARESET),
        .beat       (beat),
        .tlast      (bus.axis_tlast),
        .state      (pkt_state),
        .first_beat (first_beat),
        .last_beat  (last_beat)
    );

    // A packet that has started but not ended holds off the apply until its tlast beat.
    assign apply  = cfg_pending_q & (((pkt_state == PKT_SOP) & ~beat) | last_beat);
    assign accept = bus.cfg_wr_valid & ~cfg_pending_q;

    always_comb begin
        cfg_active_d  = cfg_active_q;
        cfg_word_d    = cfg_word_q;
        cfg_pending_d = cfg_pending_q;
        decision_d    = first_beat ? sel : decision_q;
        if (apply) begin
            cfg_active_d  = cfg_word_q;
            cfg_pending_d = 1'b0;
        end
        if (accept) begin
            cfg_word_d    = bus.cfg_wr_data;
            cfg_pending_d = 1'b1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            cfg_active_q  <= RESET_CFG;
            cfg_word_q    <= '0;
            cfg_pending_q <= 1'b0;
            decision_q    <= 1'b0;
        end else begin
            cfg_active_q  <= cfg_active_d;
            cfg_word_q    <= cfg_word_d;
            cfg_pending_q <= cfg_pending_d;
            decision_q    <= decision_d;
        end
    end

    assign bus.cfg_wr_ready = ~cfg_pending_q;
    assign bus.cfg_pending  = cfg_pending_q;
    assign bus.cfg_active   = cfg_active_q;
    assign bus.encap_proto  = cfg_active_q[PROTO_LSB +: 8];
    assign bus.decap_active = bus.axis_tvalid & ((pkt_state == PKT_SOP) ? sel : decision_q);

`ifdef DECAP_SCHED_CNT_EN
    logic [31:0] decap_pkt_cnt_q, decap_pkt_cnt_d;
    logic [31:0] pass_pkt_cnt_q, pass_pkt_cnt_d;

    always_comb begin
        decap_pkt_cnt_d = decap_pkt_cnt_q;
        pass_pkt_cnt_d  = pass_pkt_cnt_q;
        if (bus.cnt_clear) begin
            decap_pkt_cnt_d = '0;
            pass_pkt_cnt_d  = '0;
        end else if (first_beat) begin
            if (sel) decap_pkt_cnt_d = decap_pkt_cnt_q + 32'd1;
            else     pass_pkt_cnt_d  = pass_pkt_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            decap_pkt_cnt_q <= '0;
            pass_pkt_cnt_q  <= '0;
        end else begin
            decap_pkt_cnt_q <= decap_pkt_cnt_d;
            pass_pkt_cnt_q  <= pass_pkt_cnt_d;
        end
    end

    assign bus.decap_pkt_cnt = decap_pkt_cnt_q;
    assign bus.pass_pkt_cnt  = pass_pkt_cnt_q;
`else
    logic unused_cnt_clear;
    assign unused_cnt_clear  = bus.cnt_clear;
    assign bus.decap_pkt_cnt = '0;
    assign bus.pass_pkt_cnt  = '0;
`endif

endmodule

// File: tb/tb_decap_cfg_scheduler.sv
// Bench for decap_cfg_scheduler: directed scenarios plus randomized traffic against a packet-level model.
module tb_decap_cfg_scheduler;
    import decap_pkg::*;

    localparam int          TW   = 128;
    localparam int          SPP  = 16;
    localparam logic [31:0] RCFG = 32'h00B20501;
`ifdef DECAP_SCHED_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic ACLK = 1'b0;
    logic ARESET;
    always #5 ACLK = ~ACLK;

    decap_cfg_scheduler_if #(.TUSER_W(TW)) bus();

    decap_cfg_scheduler #(
        .C_S_AXIS_TUSER_WIDTH (TW),
        .SRC_PORT_POS         (SPP),
        .RESET_CFG            (RCFG)
    ) dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .bus    (bus.slave)
    );

    int passed = 0;
    int total  = 0;

    // Reference state: config in force, queued word, whether a packet is open and its verdict.
    logic [31:0] m_cfg, m_word, m_dcnt, m_pcnt;
    logic        m_pend, m_inpkt, m_dec;

    function automatic logic sel_ref(input logic [31:0] cfg, input logic [TW-1:0] tu);
        logic [7:0] port;
        logic [7:0] mask;
        port = tu[SPP +: 8];
        mask = cfg[15:8];
        return cfg[0] && ((port & mask) != 8'h00);
    endfunction

    function automatic logic exp_decap();
        if (!bus.axis_tvalid) return 1'b0;
        if (!m_inpkt)         return sel_ref(m_cfg, bus.axis_tuser);
        return m_dec;
    endfunction

    task automatic tick();
        logic beat, s;
        @(posedge ACLK);
        #1;
        beat = bus.axis_tvalid && bus.axis_tready;
        s    = sel_ref(m_cfg, bus.axis_tuser);
        if (ARESET) begin
            m_cfg = RCFG; m_word = '0; m_pend = 0; m_inpkt = 0; m_dec = 0;
            m_dcnt = 0; m_pcnt = 0;
        end else begin
            if (CNT_EN) begin
                if (bus.cnt_clear) begin
                    m_dcnt = 0; m_pcnt = 0;
                end else if (beat && !m_inpkt) begin
                    if (s) m_dcnt = m_dcnt + 1;
                    else   m_pcnt = m_pcnt + 1;
                end
            end
            if (m_pend && ((!m_inpkt && !beat) || (beat && bus.axis_tlast))) begin
                m_cfg  = m_word;
                m_pend = 0;
            end else if (bus.cfg_wr_valid && !m_pend) begin
                m_word = bus.cfg_wr_data;
                m_pend = 1;
            end
            if (beat) begin
                if (!m_inpkt && !bus.axis_tlast) m_dec = s;
                m_inpkt = !bus.axis_tlast;
            end
        end
    endtask

    task automatic drive(input logic v, input logic r, input logic l, input logic [7:0] port);
        logic [TW-1:0] tu;
        tu = {$urandom, $urandom, $urandom, $urandom};
        tu[SPP +: 8] = port;
        bus.axis_tvalid = v;
        bus.axis_tready = r;
        bus.axis_tlast  = l;
        bus.axis_tuser  = tu;
        #1;
    endtask

    task automatic test_reset();
        ARESET = 1'b1;
        bus.cfg_wr_valid = 0; bus.cfg_wr_data = '0; bus.cnt_clear = 0;
        drive(0, 0, 0, 8'h00);
        tick(); tick();
        ARESET = 1'b0;
        #1;
        total++; if (bus.cfg_active !== RCFG) $display("FAIL reset_cfg got %h want %h", bus.cfg_active, RCFG); else passed++;
        total++; if (bus.cfg_pending !== 1'b0) $display("FAIL reset_pending got %b want 0", bus.cfg_pending); else passed++;
        total++; if (bus.cfg_wr_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", bus.cfg_wr_ready); else passed++;
        total++; if (bus.encap_proto !== 8'hB2) $display("FAIL reset_proto got %h want b2", bus.encap_proto); else passed++;
        total++; if (bus.decap_active !== 1'b0) $display("FAIL reset_decap got %b want 0", bus.decap_active); else passed++;
        total++; if (bus.decap_pkt_cnt !== 32'd0 || bus.pass_pkt_cnt !== 32'd0)
            $display("FAIL reset_cnt got %0d/%0d want 0/0", bus.decap_pkt_cnt, bus.pass_pkt_cnt); else passed++;
    endtask

    task automatic test_single_beat();
        drive(1, 1, 1, 8'h01);
        total++; if (bus.decap_active !== 1'b1) $display("FAIL single_decap got %b want 1", bus.decap_active); else passed++;
        tick();
        drive(0, 0, 0, 8'h00);
        total++; if (bus.decap_pkt_cnt !== (CNT_EN ? 32'd1 : 32'd0))
            $display("FAIL single_cnt got %0d want %0d", bus.decap_pkt_cnt, CNT_EN ? 1 : 0); else passed++;
    endtask

    task automatic test_pass_packet();
        for (int b = 0; b < 4; b++) begin
            drive(1, 1, b == 3, 8'h02);
            total++; if (bus.decap_active !== 1'b0) $display("FAIL pass_decap beat %0d got %b want 0", b, bus.decap_active); else passed++;
            tick();
        end
        drive(0, 0, 0, 8'h00);
        total++; if (bus.pass_pkt_cnt !== (CNT_EN ? 32'd1 : 32'd0))
            $display("FAIL pass_cnt got %0d want %0d", bus.pass_pkt_cnt, CNT_EN ? 1 : 0); else passed++;
    endtask

    task automatic test_mid_write();
        drive(1, 1, 0, 8'h02);
        tick();
        bus.cfg_wr_valid = 1; bus.cfg_wr_data = 32'h00B20201;
        for (int b = 1; b < 4; b++) begin
            drive(1, 1, b == 3, 8'h02);
            total++; if (bus.decap_active !== 1'b0) $display("FAIL midwr_decap beat %0d got %b want 0", b, bus.decap_active); else passed++;
            if (b > 1) begin
                total++; if (bus.cfg_pending !== 1'b1) $display("FAIL midwr_pending beat %0d got %b want 1", b, bus.cfg_pending); else passed++;
            end
            tick();
            bus.cfg_wr_valid = 0;
        end
        drive(0, 0, 0, 8'h00);
        total++; if (bus.cfg_pending !== 1'b0 || bus.cfg_active !== 32'h00B20201)
            $display("FAIL midwr_apply got %b/%h want 0/00b20201", bus.cfg_pending, bus.cfg_active); else passed++;
        drive(1, 1, 1, 8'h02);
        total++; if (bus.decap_active !== 1'b1) $display("FAIL midwr_next got %b want 1", bus.decap_active); else passed++;
        tick();
        drive(0, 0, 0, 8'h00);
    endtask

    task automatic test_idle_write();
        bus.cfg_wr_valid = 1; bus.cfg_wr_data = 32'h00110000;
        #1;
        tick();
        bus.cfg_wr_valid = 0;
        #1;
        total++; if (bus.cfg_pending !== 1'b1 || bus.cfg_wr_ready !== 1'b0 || bus.cfg_active !== 32'h00B20201)
            $display("FAIL idle_accept got %b/%b/%h want 1/0/00b20201", bus.cfg_pending, bus.cfg_wr_ready, bus.cfg_active); else passed++;
        tick();
        total++; if (bus.cfg_active !== 32'h00110000 || bus.cfg_wr_ready !== 1'b1)
            $display("FAIL idle_apply got %h/%b want 00110000/1", bus.cfg_active, bus.cfg_wr_ready); else passed++;
        total++; if (bus.encap_proto !== 8'h11) $display("FAIL idle_proto got %h want 11", bus.encap_proto); else passed++;
        drive(1, 1, 1, 8'hFF);
        total++; if (bus.decap_active !== 1'b0) $display("FAIL idle_disabled got %b want 0", bus.decap_active); else passed++;
        tick();
        drive(0, 0, 0, 8'h00);
    endtask

    task automatic test_back_to_back();
        bus.cfg_wr_valid = 1; bus.cfg_wr_data = 32'h00AA0301;
        #1;
        total++; if (bus.cfg_wr_ready !== 1'b1) $display("FAIL b2b_ready0 got %b want 1", bus.cfg_wr_ready); else passed++;
        tick();
        bus.cfg_wr_data = 32'h00CC0C01;
        #1;
        total++; if (bus.cfg_wr_ready !== 1'b0) $display("FAIL b2b_apply_cycle_ready got %b want 0", bus.cfg_wr_ready); else passed++;
        tick();
        total++; if (bus.cfg_active !== 32'h00AA0301 || bus.cfg_wr_ready !== 1'b1)
            $display("FAIL b2b_first got %h/%b want 00aa0301/1", bus.cfg_active, bus.cfg_wr_ready); else passed++;
        tick();
        bus.cfg_wr_valid = 0;
        #1;
        total++; if (bus.cfg_pending !== 1'b1) $display("FAIL b2b_second_accept got %b want 1", bus.cfg_pending); else passed++;
        tick();
        total++; if (bus.cfg_active !== 32'h00CC0C01 || bus.cfg_pending !== 1'b0)
            $display("FAIL b2b_second got %h/%b want 00cc0c01/0", bus.cfg_active, bus.cfg_pending); else passed++;
    endtask

    task automatic test_reset_mid();
        drive(1, 1, 0, 8'h04);
        tick();
        drive(0, 0, 0, 8'h00);
        bus.cfg_wr_valid = 1; bus.cfg_wr_data = 32'h00000000;
        tick();
        bus.cfg_wr_valid = 0;
        ARESET = 1;
        tick();
        ARESET = 0;
        #1;
        total++; if (bus.cfg_active !== RCFG || bus.cfg_pending !== 1'b0)
            $display("FAIL rstmid_cfg got %h/%b want %h/0", bus.cfg_active, bus.cfg_pending, RCFG); else passed++;
        drive(1, 1, 0, 8'h01);
        total++; if (bus.decap_active !== 1'b1) $display("FAIL rstmid_sop got %b want 1", bus.decap_active); else passed++;
        tick();
        drive(1, 1, 1, 8'h02);
        total++; if (bus.decap_active !== 1'b1) $display("FAIL rstmid_held got %b want 1", bus.decap_active); else passed++;
        tick();
        drive(0, 0, 0, 8'h00);
    endtask

`ifdef DECAP_SCHED_CNT_EN
    task automatic test_counters();
        bus.cnt_clear = 1;
        drive(1, 1, 1, 8'h01);
        tick();
        bus.cnt_clear = 0;
        drive(0, 0, 0, 8'h00);
        total++; if (bus.decap_pkt_cnt !== 32'd0 || bus.pass_pkt_cnt !== 32'd0)
            $display("FAIL cnt_clear_prio got %0d/%0d want 0/0", bus.decap_pkt_cnt, bus.pass_pkt_cnt); else passed++;
        force dut.decap_pkt_cnt_q = 32'hFFFFFFFF;
        #1;
        release dut.decap_pkt_cnt_q;
        m_dcnt = 32'hFFFFFFFF;
        drive(1, 1, 1, 8'h01);
        tick();
        drive(0, 0, 0, 8'h00);
        total++; if (bus.decap_pkt_cnt !== 32'd0) $display("FAIL cnt_wrap got %h want 0", bus.decap_pkt_cnt); else passed++;
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            logic [7:0] port;
            port = ($urandom_range(0, 9) == 0) ? 8'h00 : (8'h01 << $urandom_range(0, 7));
            ARESET = ($urandom_range(0, 99) == 0);
            bus.cnt_clear = ($urandom_range(0, 39) == 0);
            bus.cfg_wr_valid = ($urandom_range(0, 4) == 0);
            bus.cfg_wr_data = {$urandom_range(0, 255) == 0 ? 8'h00 : 8'h5A, 8'($urandom), 8'($urandom), 7'($urandom), 1'($urandom_range(0, 3) != 0)};
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 3, port);
            total++; if (bus.decap_active !== exp_decap())
                $display("FAIL rnd_decap cyc %0d got %b want %b", c, bus.decap_active, exp_decap()); else passed++;
            total++; if (bus.cfg_active !== m_cfg || bus.encap_proto !== m_cfg[23:16])
                $display("FAIL rnd_cfg cyc %0d got %h want %h", c, bus.cfg_active, m_cfg); else passed++;
            total++; if (bus.cfg_pending !== m_pend || bus.cfg_wr_ready !== !m_pend)
                $display("FAIL rnd_pending cyc %0d got %b want %b", c, bus.cfg_pending, m_pend); else passed++;
            total++; if (bus.decap_pkt_cnt !== m_dcnt || bus.pass_pkt_cnt !== m_pcnt)
                $display("FAIL rnd_cnt cyc %0d got %0d/%0d want %0d/%0d", c, bus.decap_pkt_cnt, bus.pass_pkt_cnt, m_dcnt, m_pcnt); else passed++;
            tick();
        end
        ARESET = 0; bus.cfg_wr_valid = 0; bus.cnt_clear = 0;
        drive(0, 0, 0, 8'h00);
    endtask

    initial begin
        m_cfg = RCFG; m_word = '0; m_pend = 0; m_inpkt = 0; m_dec = 0; m_dcnt = 0; m_pcnt = 0;
        test_reset();
        test_single_beat();
        test_pass_packet();
        test_mid_write();
        test_idle_write();
        test_back_to_back();
        test_reset_mid();
`ifdef DECAP_SCHED_CNT_EN
        test_counters();
`endif
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
